// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit FIFO block:
//   DEPTH_DEFAULT - default FIFO capacity in bytes
//   tx_state_t    - launch/handshake FSM states (IDLE, SEND, RELEASE)
//   fifo_cw       - width of a count that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for a queued byte
    SEND    = 2'd1,  // tx_en high, waiting for the transmitter to report done
    RELEASE = 2'd2   // tx_en low, waiting for done to drop before the next byte
  } tx_state_t;

  // Occupancy counters need one extra bit so that "completely full" is
  // distinguishable from "empty" when the pointers have wrapped.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO feeding the UART transmit launcher.
//   clk, rst_n : clock and synchronous active-low reset
//   wr_en      : write strobe (one byte per cycle)
//   wr_data    : byte to queue
//   pop        : consume the head byte (ignored while empty)
//   head       : current head byte (valid when empty = 0)
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : bytes currently stored
//   overflow   : one-cycle pulse after a write arrived while full
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          pop,
  output logic [7:0]                    head,
  output logic                          full,
  output logic                          empty,
  output logic [fifo_cw(DEPTH)-1:0]     count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cw(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          do_pop;

  // Full and empty come straight from the registered count, so a write that
  // arrives while full is dropped even if a pop frees a slot in the same cycle.
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = wr_en && !full;
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register in a block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(accept) - CW'(do_pop);
      overflow <= wr_en && full;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count
  // already makes any stale contents unreachable, and leaving it unreset lets
  // it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (rst_n && accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue in front of a UART transmitter with an enable/done handshake.
// The FIFO accepts writes at any time; a small FSM pops one byte at a time,
// raises tx_en until the transmitter reports done, then waits for done to
// fall before launching the next byte.
//   clk, rst_n : clock and synchronous active-low reset
//   wr_en      : bus write strobe
//   wr_data    : byte to queue
//   full/empty : FIFO status
//   count      : bytes queued, excluding the byte in flight
//   overflow   : one-cycle pulse when a write is dropped
//   tx_data    : byte presented to the transmitter (holds the last byte sent)
//   tx_en      : transmitter enable
//   tx_done    : transmitter done level
//   busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [7:0]                    tx_data,
  output logic                          tx_en,
  input  logic                          tx_done,
  output logic                          busy
);

  tx_state_t  state;
  logic       pop;
  logic [7:0] head;

  // The head is consumed at the same edge it is copied into tx_data.
  assign pop  = (state == IDLE) && !empty;
  assign busy = (state != IDLE);

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            tx_data <= head;
            tx_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_done) begin
            tx_en <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Never relaunch while the transmitter still reports done,
          // otherwise the next byte could be mistaken as already finished.
          if (!tx_done) state <= IDLE;
        end
        default: begin
          tx_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed scenarios followed by random traffic, each cycle compared against
// a queue-based reference model of the FIFO and the enable/done handshake.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_done;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int step_n = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_en;
  logic       m_busy;
  logic       m_ovf;
  logic [7:0] m_data;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (step %0d): observed=%0h expected=%0h", tag, step_n, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model: the byte in flight is either
  // being sent (enable high), waiting for done to clear, or there is none.
  task automatic model_edge(input logic r, input logic w, input logic [7:0] d, input logic dn);
    bit was_full;
    bit launch;
    if (!r) begin
      q.delete();
      m_en   = 1'b0;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_data = 8'h00;
    end else begin
      was_full = (q.size() == DEPTH);
      launch   = !m_busy && (q.size() != 0);
      if (m_busy && m_en && dn)        m_en   = 1'b0;
      else if (m_busy && !m_en && !dn) m_busy = 1'b0;
      if (launch) begin
        m_data = q.pop_front();
        m_en   = 1'b1;
        m_busy = 1'b1;
      end
      m_ovf = w && was_full;
      if (w && !was_full) q.push_back(d);
    end
  endtask

  task automatic compare_all();
    check("tx_en",    32'(tx_en),    32'(m_en));
    check("tx_data",  32'(tx_data),  32'(m_data));
    check("busy",     32'(busy),     32'(m_busy));
    check("count",    32'(count),    32'(q.size()));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive inputs away from the edge, take one edge, sample 1 time unit later.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic dn);
    rst_n   = r;
    wr_en   = w;
    wr_data = d;
    tx_done = dn;
    @(posedge clk);
    model_edge(r, w, d, dn);
    #1;
    step_n++;
    compare_all();
  endtask

  task automatic finish_handshake();
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    m_en = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
    #2;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data",  32'(tx_data), 32'h00);

    // Single byte with a 3-cycle done pulse
    step(1'b1, 1'b1, 8'h95, 1'b0);
    check("single_cnt", 32'(count), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("single_en",   32'(tx_en),   32'd1);
    check("single_data", 32'(tx_data), 32'h95);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("single_drop", 32'(tx_en), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("single_busy_hold", 32'(busy), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_idle_data", 32'(tx_data), 32'h95);

    // Order: A1, B2, C3 back to back
    step(1'b1, 1'b1, 8'hA1, 1'b0);
    step(1'b1, 1'b1, 8'hB2, 1'b0);
    check("order_a1", 32'(tx_data), 32'hA1);
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    check("order_cnt2", 32'(count), 32'd2);
    finish_handshake();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("order_b2",   32'(tx_data), 32'hB2);
    check("order_cnt1", 32'(count),   32'd1);
    finish_handshake();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("order_c3",   32'(tx_data), 32'hC3);
    check("order_cnt0", 32'(count),   32'd0);
    finish_handshake();

    // Full / overflow with done held low
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    check("ovf_inflight", 32'(tx_data), 32'h01);
    check("ovf_cnt8",     32'(count),   32'd8);
    check("ovf_full",     32'(full),    32'd1);
    step(1'b1, 1'b1, 8'h0A, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_keep8", 32'(count),    32'd8);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    for (int i = 2; i <= 9; i++) begin
      finish_handshake();
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("ovf_drain", 32'(tx_data), 32'(i));
    end
    finish_handshake();

    // Simultaneous write and pop at count = 1
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0);
    finish_handshake();
    check("simul_pre_cnt", 32'(count), 32'd1);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    check("simul_cnt",  32'(count),   32'd1);
    check("simul_data", 32'(tx_data), 32'h22);
    finish_handshake();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("simul_next", 32'(tx_data), 32'h33);
    finish_handshake();

    // Reset mid-SEND with 3 bytes queued
    step(1'b1, 1'b1, 8'h44, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("rstmid_cnt3", 32'(count), 32'd3);
    step(1'b0, 1'b1, 8'h88, 1'b0);
    check("rstmid_en",    32'(tx_en), 32'd0);
    check("rstmid_cnt",   32'(count), 32'd0);
    check("rstmid_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'(i & 1));
      check("rstmid_quiet", 32'(tx_en), 32'd0);
    end

    // Stuck done
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("stuck_b1", 32'(tx_data), 32'h99);
    check("stuck_en", 32'(tx_en),   32'd1);
    step(1'b1, 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      check("stuck_wait_en",   32'(tx_en), 32'd0);
      check("stuck_wait_busy", 32'(busy),  32'd1);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("stuck_release_en", 32'(tx_en), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("stuck_b2",    32'(tx_data), 32'hAA);
    check("stuck_b2_en", 32'(tx_en),   32'd1);
    finish_handshake();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 63) != 0),
           1'($urandom_range(0, 2) != 0),
           8'($urandom),
           1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
